// File: rtl/riscv151.sv
// Non-pipelined RV32I core (FETCH/DECODE/EXECUTE/WRITEBACK) with a 16 KiB BIOS RAM
// and a memory-mapped 8N1 UART at 0x8000_0000.

module riscv151_bios_mem (
    input  logic        clk,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:4095];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

module riscv151 #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic FPGA_SERIAL_RX,
    output logic FPGA_SERIAL_TX
);
    localparam int CLKS = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int CW   = $clog2(CLKS);

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_IMM = 7'h13, OP_REG = 7'h33;

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
    state_t state;

    logic [31:0] pc, instr, rs1_val, rs2_val, alu_q, npc_q, io_rdata;
    logic [31:0] regs [1:31];
    logic [1:0]  ld_lo;
    logic        ld_bios;

    logic [31:0] bios_rdata, st_wdata, fetched, ea, alu_out, exec_result, next_pc;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, ld_word, ld_shift, ld_val, wb_data;
    logic [15:0] ld_half;
    logic [11:0] bios_addr;
    logic [3:0]  st_be;
    logic [6:0]  opcode;
    logic [4:0]  wb_rd, dec_rs1, dec_rs2;
    logic [2:0]  f3;
    logic        is_load, is_store, writes_rd, taken, bios_we, rf_we, tx_wr, rx_rd;

    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [3:0]    tx_bits, rx_bits;
    logic          tx_busy, tx_ready;
    logic [1:0]    rx_sync;
    logic          rx_prev, rx_busy, rx_valid, new_byte;
    logic [7:0]    rx_shift, rx_data;

    assign opcode = instr[6:0];
    assign wb_rd  = instr[11:7];
    assign f3     = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // An unmapped fetch decodes as all-zero, which falls through as a NOP.
    assign fetched = (pc[31:28] == 4'h4) ? bios_rdata : 32'h0;
    assign dec_rs1 = fetched[19:15];
    assign dec_rs2 = fetched[24:20];

    assign is_load   = (opcode == OP_LOAD) && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    assign is_store  = (opcode == OP_STORE) && !f3[2] && (f3 != 3'b011);
    assign writes_rd = is_load || (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                       (opcode == OP_JALR) || (opcode == OP_IMM) || (opcode == OP_REG);
    assign ea        = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign alu_b     = (opcode == OP_REG) ? rs2_val : imm_i;

    always_comb begin
        alu_out = 32'h0;
        case (f3)
            3'b000: alu_out = ((opcode == OP_REG) && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'b0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = instr[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: taken = (rs1_val < rs2_val);
            3'b111: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        exec_result = alu_out;
        next_pc     = pc + 32'd4;
        case (opcode)
            OP_LUI:    exec_result = imm_u;
            OP_AUIPC:  exec_result = pc + imm_u;
            OP_JAL:    begin exec_result = pc + 32'd4; next_pc = pc + imm_j; end
            OP_JALR:   begin exec_result = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            OP_BRANCH: if (taken) next_pc = pc + imm_b;
            default:   ;
        endcase
    end

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = rs2_val;
        case (f3)
            3'b000:  begin st_be = 4'b0001 << ea[1:0]; st_wdata = {4{rs2_val[7:0]}}; end
            3'b001:  begin st_be = ea[1] ? 4'b1100 : 4'b0011; st_wdata = {2{rs2_val[15:0]}}; end
            default: st_be = 4'b1111;
        endcase
    end

    assign ld_word  = ld_bios ? bios_rdata : io_rdata;
    assign ld_shift = ld_word >> {ld_lo, 3'b000};
    assign ld_half  = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_val = 32'h0;
        case (f3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_val = ld_word;
            3'b100:  ld_val = {24'b0, ld_shift[7:0]};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = 32'h0;
        endcase
    end

    // Side effects are gated by rst so nothing commits on the reset edge.
    assign wb_data   = is_load ? ld_val : alu_q;
    assign rf_we     = rst && (state == WRITEBACK) && writes_rd && (wb_rd != 5'd0);
    assign bios_addr = (state == EXECUTE) ? ea[13:2] : pc[13:2];
    assign bios_we   = rst && (state == EXECUTE) && is_store && (ea[31:28] == 4'h4);
    assign tx_ready  = !tx_busy;
    assign tx_wr     = rst && (state == EXECUTE) && is_store && (ea == 32'h8000_0008) && tx_ready;
    assign rx_rd     = rst && (state == EXECUTE) && is_load && (ea == 32'h8000_0004);

    riscv151_bios_mem bios_mem (
        .clk   (clk),
        .addr  (bios_addr),
        .we    (bios_we),
        .be    (st_be),
        .wdata (st_wdata),
        .rdata (bios_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= 32'h4000_0000;
            instr    <= 32'h0;
            rs1_val  <= 32'h0;
            rs2_val  <= 32'h0;
            alu_q    <= 32'h0;
            npc_q    <= 32'h0;
            io_rdata <= 32'h0;
            ld_lo    <= 2'b00;
            ld_bios  <= 1'b0;
            for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    instr   <= fetched;
                    rs1_val <= (dec_rs1 == 5'd0) ? 32'h0 : regs[dec_rs1];
                    rs2_val <= (dec_rs2 == 5'd0) ? 32'h0 : regs[dec_rs2];
                    state   <= EXECUTE;
                end
                EXECUTE: begin
                    alu_q   <= exec_result;
                    npc_q   <= next_pc;
                    ld_lo   <= ea[1:0];
                    ld_bios <= (ea[31:28] == 4'h4);
                    if (ea == 32'h8000_0000)      io_rdata <= {30'b0, rx_valid, tx_ready};
                    else if (ea == 32'h8000_0004) io_rdata <= {24'b0, rx_data};
                    else                          io_rdata <= 32'h0;
                    state   <= WRITEBACK;
                end
                default: begin
                    if (rf_we) regs[wb_rd] <= wb_data;
                    pc    <= npc_q;
                    state <= FETCH;
                end
            endcase
        end
    end

    // The shifter refills with ones, so the line idles high once the stop bit is gone.
    assign FPGA_SERIAL_TX = tx_shift[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_shift <= '1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= 4'd0;
        end else if (tx_wr) begin
            tx_shift <= {1'b1, rs2_val[7:0], 1'b0};
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bits  <= 4'd0;
        end else if (tx_busy) begin
            if (tx_cnt == CW'(CLKS - 1)) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bits  <= tx_bits + 4'd1;
                if (tx_bits == 4'd9) tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // rx_bits: 0 = start, 1..8 = data LSB first, 9 = stop.
    assign new_byte = rx_busy && (rx_cnt == '0) && (rx_bits == 4'd9) && rx_sync[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bits  <= 4'd0;
            rx_shift <= 8'h0;
            rx_data  <= 8'h0;
            rx_valid <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], FPGA_SERIAL_RX};
            rx_prev <= rx_sync[1];
            if (!rx_busy) begin
                if (rx_prev && !rx_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(CLKS / 2);
                    rx_bits <= 4'd0;
                end
            end else if (rx_cnt == '0) begin
                rx_cnt  <= CW'(CLKS - 1);
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd0) begin
                    if (rx_sync[1]) rx_busy <= 1'b0;
                end else if (rx_bits < 4'd9) begin
                    rx_shift <= {rx_sync[1], rx_shift[7:1]};
                end else begin
                    rx_busy <= 1'b0;
                    if (rx_sync[1]) rx_data <= rx_shift;
                end
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end
            if (new_byte)   rx_valid <= 1'b1;
            else if (rx_rd) rx_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv151.sv
// Bench for riscv151: runs a small BIOS program, scoreboards register writebacks
// against a precomputed queue and checks the UART waveforms and reset behaviour.

module tb_riscv151;
    localparam int CLKS = 50_000_000 / 115_200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic tx;

    riscv151 dut (
        .clk            (clk),
        .rst            (rst),
        .FPGA_SERIAL_RX (rx),
        .FPGA_SERIAL_TX (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [31:0] prog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] vi, v1, vf, vd, vo;
        vi = imm; v1 = rs1; vf = f3; vd = rd; vo = op;
        return {vi[11:0], v1[4:0], vf[2:0], vd[4:0], vo[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] vi, v2, v1, vf;
        vi = imm; v2 = rs2; v1 = rs1; vf = f3;
        return {vi[11:5], v2[4:0], v1[4:0], vf[2:0], vi[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] v7, v2, v1, vf, vd;
        v7 = f7; v2 = rs2; v1 = rs1; vf = f3; vd = rd;
        return {v7[6:0], v2[4:0], v1[4:0], vf[2:0], vd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] vi, v2, v1, vf;
        vi = imm; v2 = rs2; v1 = rs1; vf = f3;
        return {vi[12], vi[10:5], v2[4:0], v1[4:0], vf[2:0], vi[4:1], vi[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] vi, vd, vo;
        vi = imm20; vd = rd; vo = op;
        return {vi[19:0], vd[4:0], vo[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] vi, vd;
        vi = imm; vd = rd;
        return {vi[20], vi[10:1], vi[11], vi[19:12], vd[4:0], 7'h6f};
    endfunction

    task automatic push_exp(input int rd, input logic [31:0] val);
        logic [31:0] r;
        r = rd;
        exp_q.push_back({r[4:0], val});
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (CLKS) @(negedge clk);
    endtask

    // Scratch registers x28..x31 are used by the UART polling loops and are not tracked.
    always @(negedge clk) begin
        if (rst && dut.rf_we && dut.wb_rd < 5'd28) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write_rd", {27'd0, dut.wb_rd}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check($sformatf("sb_x%0d_rd", e[36:32]), {27'd0, dut.wb_rd}, {27'd0, e[36:32]});
                check($sformatf("sb_x%0d_val", e[36:32]), dut.wb_data, e[31:0]);
            end
        end
    end

    initial begin
        #(60_000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] frame;
        int n;

        prog.push_back(enc_i(5, 0, 0, 1, 7'h13));            // 0  addi x1,x0,5
        prog.push_back(enc_i(-7, 1, 0, 2, 7'h13));           // 1  addi x2,x1,-7
        prog.push_back(enc_u(8, 3, 7'h37));                  // 2  lui x3,0x8
        prog.push_back(enc_i(32'hF0, 3, 0, 3, 7'h13));       // 3  addi x3,x3,0xf0
        prog.push_back(enc_j(8, 1));                         // 4  jal x1,+8
        prog.push_back(enc_i(1, 0, 0, 9, 7'h13));            // 5  skipped
        prog.push_back(enc_u(32'h40000, 4, 7'h37));          // 6  lui x4,0x40000
        prog.push_back(enc_s(32'h100, 3, 4, 2));             // 7  sw x3,0x100(x4)
        prog.push_back(enc_i(32'h100, 4, 0, 5, 7'h03));      // 8  lb
        prog.push_back(enc_i(32'h100, 4, 4, 6, 7'h03));      // 9  lbu
        prog.push_back(enc_i(32'h100, 4, 1, 7, 7'h03));      // 10 lh
        prog.push_back(enc_b(8, 0, 0, 1));                   // 11 bne x0,x0 (not taken)
        prog.push_back(enc_i(32'h101, 4, 0, 8, 7'h03));      // 12 lb byte 1
        prog.push_back(enc_s(32'h102, 2, 4, 1));             // 13 sh x2,0x102(x4)
        prog.push_back(enc_i(32'h100, 4, 2, 25, 7'h03));     // 14 lw
        prog.push_back(enc_r(7'h20, 1, 2, 0, 10));           // 15 sub x10,x2,x1
        prog.push_back(enc_r(7'h20, 6, 2, 5, 11));           // 16 sra x11,x2,x6
        prog.push_back(enc_r(0, 2, 1, 3, 12));               // 17 sltu x12,x1,x2
        prog.push_back(enc_r(0, 2, 1, 2, 13));               // 18 slt x13,x1,x2
        prog.push_back(enc_i(7, 0, 0, 0, 7'h13));            // 19 addi x0,x0,7
        prog.push_back(enc_r(0, 0, 0, 0, 26));               // 20 add x26,x0,x0
        prog.push_back(32'h0000_0000);                       // 21 nop
        prog.push_back(enc_b(8, 0, 0, 0));                   // 22 beq x0,x0,+8
        prog.push_back(enc_i(2, 0, 0, 9, 7'h13));            // 23 skipped
        prog.push_back(enc_u(1, 14, 7'h17));                 // 24 auipc x14,1
        prog.push_back(enc_i(32'h6D, 4, 0, 15, 7'h67));      // 25 jalr x15,0x6d(x4)
        prog.push_back(enc_i(3, 0, 0, 9, 7'h13));            // 26 skipped
        prog.push_back(enc_i(32'h55, 0, 0, 16, 7'h13));      // 27 addi x16,x0,0x55
        prog.push_back(enc_u(32'h80000, 17, 7'h37));         // 28 lui x17,0x80000
        prog.push_back(enc_s(8, 16, 17, 2));                 // 29 sw x16 -> tx
        prog.push_back(enc_s(8, 0, 17, 2));                  // 30 sw x0 -> tx while busy
        prog.push_back(enc_i(0, 17, 2, 18, 7'h03));          // 31 lw status
        prog.push_back(enc_i(0, 17, 2, 28, 7'h03));          // 32 poll tx_ready
        prog.push_back(enc_i(1, 28, 7, 29, 7'h13));          // 33
        prog.push_back(enc_b(-8, 0, 29, 0));                 // 34
        prog.push_back(enc_i(0, 17, 2, 21, 7'h03));          // 35 lw status
        prog.push_back(enc_i(0, 17, 2, 28, 7'h03));          // 36 poll rx_valid
        prog.push_back(enc_i(2, 28, 7, 29, 7'h13));          // 37
        prog.push_back(enc_b(-8, 0, 29, 0));                 // 38
        prog.push_back(enc_i(0, 17, 2, 22, 7'h03));          // 39 lw status
        prog.push_back(enc_i(4, 17, 2, 23, 7'h03));          // 40 lw rx data
        prog.push_back(enc_i(0, 17, 2, 24, 7'h03));          // 41 lw status
        prog.push_back(enc_s(8, 16, 17, 2));                 // 42 sw x16 -> tx
        prog.push_back(enc_j(0, 0));                         // 43 jal x0,0

        for (int i = 0; i < 4096; i++) dut.bios_mem.mem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) dut.bios_mem.mem[i] = prog[i];

        push_exp(1, 32'd5);
        push_exp(2, 32'hFFFF_FFFE);
        push_exp(3, 32'h0000_8000);
        push_exp(3, 32'h0000_80F0);
        push_exp(1, 32'h4000_0014);
        push_exp(4, 32'h4000_0000);
        push_exp(5, 32'hFFFF_FFF0);
        push_exp(6, 32'h0000_00F0);
        push_exp(7, 32'hFFFF_80F0);
        push_exp(8, 32'hFFFF_FF80);
        push_exp(25, 32'hFFFE_80F0);
        push_exp(10, 32'hFFFF_FFFE - 32'h4000_0014);
        push_exp(11, 32'hFFFF_FFFF);
        push_exp(12, 32'd1);
        push_exp(13, 32'd0);
        push_exp(26, 32'd0);
        push_exp(14, 32'h4000_1060);
        push_exp(15, 32'h4000_0068);
        push_exp(16, 32'h0000_0055);
        push_exp(17, 32'h8000_0000);
        push_exp(18, 32'd0);
        push_exp(21, 32'd1);
        push_exp(22, 32'd3);
        push_exp(23, 32'h0000_00A5);
        push_exp(24, 32'd1);

        // Reset held for 30 cycles with the line idle.
        repeat (30) begin
            @(negedge clk);
            check("reset_tx_idle", {31'd0, tx}, 32'd1);
        end
        check("reset_pc", dut.pc, 32'h4000_0000);
        check("reset_state", {30'd0, dut.state}, 32'd0);
        check("reset_x1", dut.regs[1], 32'd0);
        check("reset_tx_ready", {31'd0, dut.tx_ready}, 32'd1);
        check("reset_rx_valid", {31'd0, dut.rx_valid}, 32'd0);

        rst = 1'b1;
        check("first_fetch_pc", dut.pc, 32'h4000_0000);
        check("first_fetch_addr", {20'd0, dut.bios_addr}, 32'd0);
        @(negedge clk);
        check("decode_after_fetch", {30'd0, dut.state}, 32'd1);

        // Transmit frame for 0x55.
        n = 0;
        while (tx === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", {31'd0, tx}, 32'd0);
        frame = {1'b1, 8'h55, 1'b0};
        repeat (CLKS / 2) @(negedge clk);
        check("tx_start_mid", {31'd0, tx}, {31'd0, frame[0]});
        check("tx_ready_in_frame", {31'd0, dut.tx_ready}, 32'd0);
        repeat (CLKS - 1 - CLKS / 2) @(negedge clk);
        check("tx_start_last_cycle", {31'd0, tx}, 32'd0);
        @(negedge clk);
        check("tx_bit0_first_cycle", {31'd0, tx}, {31'd0, frame[1]});
        for (int k = 1; k < 10; k++) begin
            repeat ((k == 1) ? CLKS / 2 : CLKS) @(negedge clk);
            check($sformatf("tx_frame_bit%0d", k), {31'd0, tx}, {31'd0, frame[k]});
        end

        // A frame with a low stop bit must be dropped; the valid one follows.
        repeat ($urandom_range(5, 50)) @(negedge clk);
        uart_send(8'h3C, 1'b0);
        repeat ($urandom_range(5, 50)) @(negedge clk);
        uart_send(8'hA5, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the second transmit frame.
        n = 0;
        while (tx === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx2_start_seen", {31'd0, tx}, 32'd0);
        repeat (1000) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_tx_ready", {31'd0, dut.tx_ready}, 32'd1);
        check("midreset_pc", dut.pc, 32'h4000_0000);
        check("midreset_state", {30'd0, dut.state}, 32'd0);
        check("midreset_x16", dut.regs[16], 32'd0);
        check("midreset_bios_kept", dut.bios_mem.mem[64], 32'hFFFE_80F0);
        repeat ($urandom_range(10, 40)) @(negedge clk);
        check("midreset_tx_held", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv151.md
RISCV151 -- requirements
Module: riscv151

Interface
REQ-001 SHALL have parameter CPU_CLOCK_FREQ, default 50_000_000, meaning core clock frequency in Hz, used for UART timing.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning UART bit rate.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port FPGA_SERIAL_RX, input, 1 bit: UART receive line, idle high.
REQ-006 SHALL have port FPGA_SERIAL_TX, output, 1 bit: UART transmit line, idle high.
REQ-007 SHALL contain an instance named bios_mem, holding array mem[0:4095] of 32-bit words, loadable by hierarchical $readmemh before reset release.

Function
REQ-008 SHALL execute RV32I base integer instructions: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP.
REQ-009 SHALL treat FENCE, ECALL, EBREAK, CSR and any unrecognised opcode (including fetched 0x00000000) as NOP: PC+4, no register or memory write.
REQ-010 SHALL be non-pipelined FSM: FETCH (drive PC to memory), DECODE (instruction valid, register reads), EXECUTE (ALU/branch resolve, issue load/store), WRITEBACK (rd write, PC update); exactly 4 cycles per instruction, then back to FETCH.
REQ-011 SHALL hold x0 at 0; writes to x0 ignored.
REQ-012 SHALL compute all arithmetic modulo 2^32; shifts use low 5 bits of shift amount; SLT/SLTI signed, SLTU/SLTIU unsigned; SRA/SRAI arithmetic.
REQ-013 SHALL compute JAL/branch targets as PC+imm, JALR target as (rs1+imm) with bit 0 cleared; link value PC+4.
REQ-014 SHALL map addr[31:28]==4'h4 to bios_mem, word index addr[13:2], synchronous read, byte-enable write; used for fetch and data.
REQ-015 SHALL map 0x8000_0000 as UART status (read-only): bit0 tx_ready, bit1 rx_valid, other bits 0.
REQ-016 SHALL map 0x8000_0004 as UART RX data (read returns byte zero-extended, clears rx_valid), 0x8000_0008 as UART TX data (write of low byte starts transmission).
REQ-017 SHALL return 0 for reads and ignore writes to any other address; fetch from unmapped address yields NOP.
REQ-018 SHALL support LB/LH (sign-extended), LBU/LHU (zero-extended), LW, SB/SH/SW with lane selection by addr[1:0]; misalignment is not trapped: LH/SH use addr[1], LW/SW ignore addr[1:0].
REQ-019 SHALL transmit UART 8N1, LSB first, bit period CPU_CLOCK_FREQ/BAUD_RATE cycles (integer division); tx_ready low from TX write until end of stop bit.
REQ-020 SHALL ignore TX data writes while tx_ready is 0.
REQ-021 SHALL receive UART 8N1: detect falling start edge, sample each bit at mid-period, require stop bit high else discard; valid byte sets rx_valid; new byte overwrites unread byte.
REQ-022 SHALL give a same-cycle RX-data read and new-byte arrival priority to the new byte (rx_valid stays 1).

Reset
REQ-023 SHALL, while rst is low at a clock edge: PC=0x4000_0000, FSM=FETCH, x1..x31=0, FPGA_SERIAL_TX=1, tx_ready=1, rx_valid=0, UART counters cleared.
REQ-024 SHALL NOT modify bios_mem contents on reset.
REQ-025 SHALL abandon any instruction or UART frame in progress when reset asserts mid-operation; no partial register or memory write may commit after the reset edge.
REQ-026 SHALL fetch word bios_mem.mem[0] in the first FETCH after rst goes high.

Verification
REQ-027 Load bios image, hold rst low 30 cycles, release -> FPGA_SERIAL_TX=1 throughout, first fetch at 0x4000_0000.
REQ-028 mem[0]=ADDI x1,x0,5; mem[1]=ADDI x2,x1,-7 -> after 8 cycles x1=5, x2=0xFFFFFFFE.
REQ-029 SW 0x000080F0 to 0x4000_0100, then LB/LBU/LH from 0x4000_0100 -> 0xFFFFFFF0, 0x000000F0, 0xFFFF80F0.
REQ-030 JAL x1,+8 at 0x4000_0010 -> x1=0x4000_0014, next fetch 0x4000_0018; BNE x0,x0 not taken -> PC+4.
REQ-031 SW 0x55 to 0x8000_0008 (defaults) -> TX low 434 cycles, then bits 1,0,1,0,1,0,1,0 each 434 cycles, stop high; status bit0=0 during frame, 1 after.
REQ-032 Drive 0xA5 8N1 on FPGA_SERIAL_RX -> status bit1=1; LW 0x8000_0004 returns 0x000000A5, bit1 then 0; rst low mid-frame -> TX=1 next cycle.
